// File: rtl/oven_pkg.sv
// Shared types, default constants and temperature/time helpers for the oven controller.
package oven_pkg;

  localparam int TEMP_W = 10;
  localparam int TIME_W = 13;

  localparam int DEF_AMBIENT_TEMP = 70;
  localparam int DEF_MIN_TEMP     = 100;
  localparam int DEF_MAX_TEMP     = 500;
  localparam int DEF_MAX_TIME     = 5999;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_SET_TEMP = 3'd1,
    ST_SET_TIME = 3'd2,
    ST_PREHEAT  = 3'd3,
    ST_COOK     = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  function automatic logic [TEMP_W-1:0] clamp_temp(
    input logic [TEMP_W-1:0] v,
    input logic [TEMP_W-1:0] lo,
    input logic [TEMP_W-1:0] hi
  );
    if (v < lo) begin
      clamp_temp = lo;
    end else if (v > hi) begin
      clamp_temp = hi;
    end else begin
      clamp_temp = v;
    end
  endfunction

  // One cooling step, floored at ambient; the extra bit keeps floor+step from wrapping.
  function automatic logic [TEMP_W-1:0] cool_temp(
    input logic [TEMP_W-1:0] cur,
    input logic [TEMP_W-1:0] step,
    input logic [TEMP_W-1:0] floor_t
  );
    logic [TEMP_W:0] floor_sum;
    floor_sum = {1'b0, floor_t} + {1'b0, step};
    if ({1'b0, cur} < floor_sum) begin
      cool_temp = floor_t;
    end else begin
      cool_temp = cur - step;
    end
  endfunction

  function automatic logic [TEMP_W-1:0] heat_temp(
    input logic [TEMP_W-1:0] cur,
    input logic [TEMP_W-1:0] tgt,
    input logic [TEMP_W-1:0] step
  );
    logic [TEMP_W:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (cur < tgt) begin
      if (sum >= {1'b0, tgt}) begin
        heat_temp = tgt;
      end else begin
        heat_temp = sum[TEMP_W-1:0];
      end
    end else if (cur > tgt) begin
      if ({1'b0, cur} <= ({1'b0, tgt} + {1'b0, step})) begin
        heat_temp = tgt;
      end else begin
        heat_temp = cur - step;
      end
    end else begin
      heat_temp = tgt;
    end
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Free-running prescaler: counts 0..TICKS_PER_SEC-1 and raises tick for one cycle on each wrap.
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic             tick_r;

  // prescaler count and registered wrap pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r  <= {CNT_W{1'b0}};
      tick_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r  <= {CNT_W{1'b0}};
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + CNT_ONE;
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/oven_controller.sv
// Oven sequencing FSM: temperature entry, time entry, preheat, cook countdown and done/cool-down,
// paced by a one-second tick; all outputs are registered.
module oven_controller #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int TEMP_STEP     = 10,
  parameter int AMBIENT_TEMP  = oven_pkg::DEF_AMBIENT_TEMP,
  parameter int MIN_TEMP      = oven_pkg::DEF_MIN_TEMP,
  parameter int MAX_TEMP      = oven_pkg::DEF_MAX_TEMP,
  parameter int MAX_TIME      = oven_pkg::DEF_MAX_TIME
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          power_sw,
  input  logic                          enter_btn,
  input  logic                          cancel_btn,
  input  logic [oven_pkg::TIME_W-1:0]   entry_value,
  output logic                          power,
  output logic                          temp_input_done,
  output logic                          time_input_done,
  output logic [oven_pkg::TEMP_W-1:0]   current_temp,
  output logic [oven_pkg::TEMP_W-1:0]   target_temp,
  output logic [oven_pkg::TIME_W-1:0]   current_time,
  output logic [oven_pkg::TIME_W-1:0]   target_time,
  output logic                          heater_on,
  output logic                          done_alarm
);

  import oven_pkg::*;

  localparam logic [TEMP_W-1:0] AMB_T     = TEMP_W'(AMBIENT_TEMP);
  localparam logic [TEMP_W-1:0] STEP_T    = TEMP_W'(TEMP_STEP);
  localparam logic [TEMP_W-1:0] MIN_T     = TEMP_W'(MIN_TEMP);
  localparam logic [TEMP_W-1:0] MAX_T     = TEMP_W'(MAX_TEMP);
  localparam logic [TEMP_W-1:0] TEMP_ZERO = {TEMP_W{1'b0}};
  localparam logic [TIME_W-1:0] MAX_TM    = TIME_W'(MAX_TIME);
  localparam logic [TIME_W-1:0] TIME_ONE  = TIME_W'(1);
  localparam logic [TIME_W-1:0] TIME_ZERO = {TIME_W{1'b0}};

  state_e state_r, state_next_s;

  logic enter_r, enter_prev_r, cancel_r, cancel_prev_r;
  logic enter_edge_s, cancel_edge_s, tick_s;

  logic [TEMP_W-1:0] temp_sel_s, cooled_s, heated_s;
  logic [TIME_W-1:0] time_sel_s;

  logic              power_next_s, temp_done_next_s, time_done_next_s;
  logic              heater_next_s, alarm_next_s;
  logic [TEMP_W-1:0] cur_temp_next_s, tgt_temp_next_s;
  logic [TIME_W-1:0] cur_time_next_s, tgt_time_next_s;

  sec_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  // button level registers for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enter_r       <= 1'b0;
      enter_prev_r  <= 1'b0;
      cancel_r      <= 1'b0;
      cancel_prev_r <= 1'b0;
    end else begin
      enter_r       <= enter_btn;
      enter_prev_r  <= enter_r;
      cancel_r      <= cancel_btn;
      cancel_prev_r <= cancel_r;
    end
  end

  assign enter_edge_s  = enter_r & ~enter_prev_r;
  assign cancel_edge_s = cancel_r & ~cancel_prev_r;

  assign temp_sel_s = clamp_temp(entry_value[TEMP_W-1:0], MIN_T, MAX_T);
  assign time_sel_s = (entry_value > MAX_TM) ? MAX_TM : entry_value;
  assign cooled_s   = tick_s ? cool_temp(current_temp, STEP_T, AMB_T) : current_temp;
  assign heated_s   = tick_s ? heat_temp(current_temp, target_temp, STEP_T) : current_temp;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_OFF;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state: power off, then cancel, then enter, then tick
  always_comb begin
    state_next_s = state_r;
    if (!power_sw) begin
      state_next_s = ST_OFF;
    end else if (cancel_edge_s && (state_r != ST_OFF)) begin
      state_next_s = ST_SET_TEMP;
    end else begin
      case (state_r)
        ST_OFF:      state_next_s = ST_SET_TEMP;
        ST_SET_TEMP: state_next_s = enter_edge_s ? ST_SET_TIME : ST_SET_TEMP;
        ST_SET_TIME: state_next_s = (enter_edge_s && (time_sel_s != TIME_ZERO)) ? ST_PREHEAT : ST_SET_TIME;
        ST_PREHEAT:  state_next_s = (current_temp == target_temp) ? ST_COOK : ST_PREHEAT;
        ST_COOK:     state_next_s = (tick_s && (current_time <= TIME_ONE)) ? ST_DONE : ST_COOK;
        ST_DONE:     state_next_s = enter_edge_s ? ST_SET_TEMP : ST_DONE;
        default:     state_next_s = ST_OFF;
      endcase
    end
  end

  // next values of the registered outputs
  always_comb begin
    power_next_s     = (state_next_s != ST_OFF);
    tgt_temp_next_s  = target_temp;
    tgt_time_next_s  = target_time;
    cur_temp_next_s  = current_temp;
    cur_time_next_s  = current_time;
    temp_done_next_s = temp_input_done;
    time_done_next_s = time_input_done;
    heater_next_s    = heater_on;
    alarm_next_s     = done_alarm;
    if (!power_sw) begin
      tgt_temp_next_s  = TEMP_ZERO;
      tgt_time_next_s  = TIME_ZERO;
      cur_time_next_s  = TIME_ZERO;
      temp_done_next_s = 1'b0;
      time_done_next_s = 1'b0;
      heater_next_s    = 1'b0;
      alarm_next_s     = 1'b0;
      cur_temp_next_s  = cooled_s;
    end else if (cancel_edge_s && (state_r != ST_OFF)) begin
      cur_time_next_s  = TIME_ZERO;
      temp_done_next_s = 1'b0;
      time_done_next_s = 1'b0;
      heater_next_s    = 1'b0;
      alarm_next_s     = 1'b0;
      if (state_r == ST_SET_TEMP) begin
        tgt_temp_next_s = temp_sel_s;
      end else if (state_r == ST_SET_TIME) begin
        tgt_time_next_s = time_sel_s;
      end else begin
        tgt_temp_next_s = target_temp;
      end
    end else begin
      case (state_r)
        ST_OFF: begin
          cur_temp_next_s = cooled_s;
        end
        ST_SET_TEMP: begin
          tgt_temp_next_s = temp_sel_s;
          if (enter_edge_s) begin
            temp_done_next_s = 1'b1;
          end else begin
            cur_temp_next_s = cooled_s;
          end
        end
        ST_SET_TIME: begin
          tgt_time_next_s = time_sel_s;
          if (enter_edge_s && (time_sel_s != TIME_ZERO)) begin
            time_done_next_s = 1'b1;
            cur_time_next_s  = time_sel_s;
            heater_next_s    = (current_temp < target_temp);
          end else begin
            cur_temp_next_s = cooled_s;
          end
        end
        ST_PREHEAT: begin
          if (current_temp == target_temp) begin
            heater_next_s = 1'b1;
          end else begin
            cur_temp_next_s = heated_s;
            heater_next_s   = (heated_s < target_temp);
          end
        end
        ST_COOK: begin
          heater_next_s = 1'b1;
          if (tick_s) begin
            if (current_time <= TIME_ONE) begin
              cur_time_next_s = TIME_ZERO;
              heater_next_s   = 1'b0;
              alarm_next_s    = 1'b1;
            end else begin
              cur_time_next_s = current_time - TIME_ONE;
            end
          end else begin
            cur_time_next_s = current_time;
          end
        end
        ST_DONE: begin
          if (enter_edge_s) begin
            temp_done_next_s = 1'b0;
            time_done_next_s = 1'b0;
            cur_time_next_s  = TIME_ZERO;
            heater_next_s    = 1'b0;
            alarm_next_s     = 1'b0;
          end else begin
            heater_next_s   = 1'b0;
            alarm_next_s    = 1'b1;
            cur_temp_next_s = cooled_s;
          end
        end
        default: begin
          cur_temp_next_s = current_temp;
        end
      endcase
    end
  end

  // output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      power           <= 1'b0;
      temp_input_done <= 1'b0;
      time_input_done <= 1'b0;
      current_temp    <= AMB_T;
      target_temp     <= TEMP_ZERO;
      current_time    <= TIME_ZERO;
      target_time     <= TIME_ZERO;
      heater_on       <= 1'b0;
      done_alarm      <= 1'b0;
    end else begin
      power           <= power_next_s;
      temp_input_done <= temp_done_next_s;
      time_input_done <= time_done_next_s;
      current_temp    <= cur_temp_next_s;
      target_temp     <= tgt_temp_next_s;
      current_time    <= cur_time_next_s;
      target_time     <= tgt_time_next_s;
      heater_on       <= heater_next_s;
      done_alarm      <= alarm_next_s;
    end
  end

endmodule
